// File: rtl/melody_game_core.sv
// Melody memory game: plays a growing note sequence and checks the echoed keys; all outputs registered, no backpressure.
// Optional MELODY_GAME_TIMEOUT_EN adds a WAIT_KEY timeout of TIMEOUT_TICKS ticks that counts as a miss.
module melody_game_core #(
  parameter int NOTE_W    = 3,
  parameter int MAX_LEN   = 8,
  parameter int TICK_DIV  = 500000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2
`ifdef MELODY_GAME_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 20
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seq_we,
  input  logic [MAX_LEN*NOTE_W-1:0] seq_in,
  input  logic                      start,
  input  logic                      key_valid,
  input  logic [NOTE_W:0]           key_code,
  output logic [NOTE_W:0]           tone_out,
  output logic                      playing,
  output logic                      miss,
  output logic                      game_win,
  output logic [4:0]                level,
  output logic [2:0]                state_out
);

  localparam int KW  = NOTE_W + 1;
  localparam int IW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW  = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_WAIT_KEY = 3'd3,
    S_ECHO     = 3'd4,
    S_WIN      = 3'd5
  } state_t;

  state_t                    state_q, state_nx;
  logic [TCW-1:0]            tick_cnt;
  logic                      tick;
  logic [PW-1:0]             phase_cnt, phase_nx;
  logic [IW-1:0]             idx, idx_nx;
  logic [4:0]                level_nx;
  logic                      loaded, loaded_nx;
  logic [MAX_LEN*NOTE_W-1:0] seq_reg, seq_nx;
  logic [NOTE_W:0]           key_lat, key_nx;
  logic                      match_q, match_nx;
  logic                      miss_nx, win_nx;
  logic [NOTE_W:0]           tone_nx;
  logic                      playing_nx;
  logic                      load_ok;
  logic                      idx_last;
  logic [NOTE_W:0]           expect_tone;

  assign tick        = (tick_cnt == TCW'(TICK_DIV - 1));
  assign idx_last    = (5'(idx) == level - 5'd1);
  assign expect_tone = {1'b0, seq_reg[int'(idx)*NOTE_W +: NOTE_W]} + KW'(1);
  assign state_out   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_cnt  <= '0;
      phase_cnt <= '0;
      idx       <= '0;
      level     <= '0;
      loaded    <= 1'b0;
      seq_reg   <= '0;
      key_lat   <= '0;
      match_q   <= 1'b0;
      tone_out  <= '0;
      playing   <= 1'b0;
      miss      <= 1'b0;
      game_win  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      tick_cnt  <= tick ? '0 : tick_cnt + TCW'(1);
      phase_cnt <= phase_nx;
      idx       <= idx_nx;
      level     <= level_nx;
      loaded    <= loaded_nx;
      seq_reg   <= seq_nx;
      key_lat   <= key_nx;
      match_q   <= match_nx;
      tone_out  <= tone_nx;
      playing   <= playing_nx;
      miss      <= miss_nx;
      game_win  <= win_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    idx_nx    = idx;
    level_nx  = level;
    key_nx    = key_lat;
    match_nx  = match_q;
    miss_nx   = 1'b0;
    win_nx    = game_win;
    phase_nx  = tick ? phase_cnt + PW'(1) : phase_cnt;
    load_ok   = (state_q == S_IDLE) || (state_q == S_WIN);
    seq_nx    = (seq_we && load_ok) ? seq_in : seq_reg;
    loaded_nx = loaded | (seq_we & load_ok);

    case (state_q)
      S_IDLE: begin
        if (start && loaded) begin
          level_nx = 5'd1;
          idx_nx   = '0;
          state_nx = S_PLAY_ON;
        end
      end
      S_PLAY_ON: begin
        if (tick && phase_cnt == PW'(ON_TICKS - 1)) state_nx = S_PLAY_OFF;
      end
      S_PLAY_OFF: begin
        if (tick && phase_cnt == PW'(OFF_TICKS - 1)) begin
          if (idx_last) begin
            idx_nx   = '0;
            state_nx = S_WAIT_KEY;
          end else begin
            idx_nx   = idx + IW'(1);
            state_nx = S_PLAY_ON;
          end
        end
      end
      S_WAIT_KEY: begin
        if (key_valid) begin
          key_nx   = key_code;
          match_nx = (key_code == expect_tone);
          state_nx = S_ECHO;
        end
`ifdef MELODY_GAME_TIMEOUT_EN
        else if (tick && phase_cnt == PW'(TIMEOUT_TICKS - 1)) begin
          miss_nx  = 1'b1;
          idx_nx   = '0;
          state_nx = S_PLAY_ON;
        end
`else
        else begin
          state_nx = S_WAIT_KEY;
        end
`endif
      end
      S_ECHO: begin
        // The compare result was captured with the key; it only takes effect once the echo ends.
        if (tick && phase_cnt == PW'(ON_TICKS - 1)) begin
          if (!match_q) begin
            miss_nx  = 1'b1;
            idx_nx   = '0;
            state_nx = S_PLAY_ON;
          end else if (!idx_last) begin
            idx_nx   = idx + IW'(1);
            state_nx = S_WAIT_KEY;
          end else if (level < 5'(MAX_LEN)) begin
            level_nx = level + 5'd1;
            idx_nx   = '0;
            state_nx = S_PLAY_ON;
          end else begin
            win_nx   = 1'b1;
            state_nx = S_WIN;
          end
        end
      end
      S_WIN: begin
        if (start) begin
          win_nx   = 1'b0;
          level_nx = 5'd1;
          idx_nx   = '0;
          state_nx = S_PLAY_ON;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (state_nx != state_q) phase_nx = '0;
  end

  // Outputs are decoded from the next-state values so the registered outputs line up with state_q.
  always_comb begin
    tone_nx    = '0;
    playing_nx = 1'b0;
    case (state_nx)
      S_PLAY_ON: begin
        tone_nx    = {1'b0, seq_nx[int'(idx_nx)*NOTE_W +: NOTE_W]} + KW'(1);
        playing_nx = 1'b1;
      end
      S_PLAY_OFF: playing_nx = 1'b1;
      S_ECHO:     tone_nx    = key_nx;
      default:    tone_nx    = '0;
    endcase
  end

endmodule

// File: tb/tb_melody_game_core.sv
// Directed table-driven bench for melody_game_core (TICK_DIV=4, ON=2, OFF=1, NOTE_W=3, MAX_LEN=4).
module tb_melody_game_core;
  localparam int NW = 3;
  localparam int ML = 4;
  localparam int S_IDLE = 0, S_ON = 1, S_OFF = 2, S_WAIT = 3, S_ECHO = 4, S_WIN = 5;
  localparam int A_NONE = 0, A_START = 1, A_KEY = 2;
  localparam logic [ML*NW-1:0] SEQ = {3'd7, 3'd0, 3'd5, 3'd2};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            seq_we = 1'b0;
  logic [ML*NW-1:0] seq_in = '0;
  logic            start = 1'b0;
  logic            key_valid = 1'b0;
  logic [NW:0]     key_code = '0;
  logic [NW:0]     tone_out;
  logic            playing, miss, game_win;
  logic [4:0]      level;
  logic [2:0]      state_out;

  int checks = 0;
  int failures = 0;
  int pe;
  int tn[4] = '{3, 6, 1, 8};

  typedef struct {
    int act; int key; int tone; int n; int lvl; int st; int m; int gw;
  } vec_t;
  vec_t tbl[$];

  melody_game_core #(
    .NOTE_W(NW), .MAX_LEN(ML), .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1)
`ifdef MELODY_GAME_TIMEOUT_EN
    , .TIMEOUT_TICKS(3)
`endif
  ) dut (
    .clk(clk), .reset(reset), .seq_we(seq_we), .seq_in(seq_in), .start(start),
    .key_valid(key_valid), .key_code(key_code), .tone_out(tone_out), .playing(playing),
    .miss(miss), .game_win(game_win), .level(level), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Bench copy of the free-running tick counter phase.
  always @(posedge clk or posedge reset) begin
    if (reset) pe <= 0;
    else       pe <= (pe + 1) % 4;
  end

  task automatic add(input int act, input int key, input int tone, input int n,
                     input int lvl, input int st, input int m, input int gw);
    vec_t v;
    v.act = act; v.key = key; v.tone = tone; v.n = n;
    v.lvl = lvl; v.st = st; v.m = m; v.gw = gw;
    tbl.push_back(v);
  endtask

  task automatic rep(input int lvl, input int act, input int m);
    for (int i = 0; i < lvl; i++) begin
      add((i == 0) ? act : A_NONE, 0, tn[i], 8, lvl, S_ON, (i == 0) ? m : 0, 0);
      add(A_NONE, 0, 0, 4, lvl, S_OFF, 0, 0);
    end
    add(A_NONE, 0, 0, 1, lvl, S_WAIT, 0, 0);
  endtask

  task automatic ech(input int key, input int lvl);
    add(A_KEY, key, key, 8, lvl, S_ECHO, 0, 0);
  endtask

  task automatic wt(input int lvl);
    add(A_NONE, 0, 0, 1, lvl, S_WAIT, 0, 0);
  endtask

  // Advance to a cycle whose tick counter is 3 so the next edge starts a full tick period.
  task automatic align();
    do begin
      @(posedge clk); #1;
    end while (pe != 3);
  endtask

  task automatic seg(input int tone, input int n, input int lvl, input int st,
                     input int m, input int gw, input string nm);
    bit bad = 0;
    logic exp_miss, exp_play;
    exp_play = (st == S_ON) || (st == S_OFF);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_miss = (i == 0) ? m[0] : 1'b0;
      if (!bad && (tone_out !== 4'(tone) || state_out !== 3'(st) || level !== 5'(lvl) ||
                   miss !== exp_miss || game_win !== gw[0] || playing !== exp_play)) begin
        bad = 1;
        $display("FAIL %s cyc%0d: tone=%0d/%0d st=%0d/%0d lvl=%0d/%0d miss=%0b/%0b win=%0b/%0b play=%0b/%0b",
                 nm, i, tone_out, tone, state_out, st, level, lvl, miss, exp_miss,
                 game_win, gw[0], playing, exp_play);
      end
    end
    checks++;
    if (bad) failures++;
  endtask

  task automatic press(input int k);
    align();
    key_valid = 1'b1; key_code = 4'(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rep(1, A_START, 0); ech(3, 1);
    rep(2, A_NONE, 0); ech(3, 2); wt(2); ech(4, 2);
    rep(2, A_NONE, 1); ech(3, 2); wt(2); ech(6, 2);
    rep(3, A_NONE, 0); ech(3, 3); wt(3); ech(6, 3); wt(3); ech(1, 3);
    rep(4, A_NONE, 0);
    for (int i = 0; i < 3; i++) begin ech(tn[i], 4); wt(4); end
    ech(8, 4);
    add(A_NONE, 0, 0, 4, 4, S_WIN, 0, 1);
    rep(1, A_START, 0); ech(0, 1); rep(1, A_NONE, 1); ech(9, 1); rep(1, A_NONE, 1);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    seg(0, 2, 0, S_IDLE, 0, 0, "reset_state");

    @(posedge clk); #1;
    seq_in = SEQ; seq_we = 1'b1;
    @(posedge clk); #1;
    seq_we = 1'b0;
    seg(0, 2, 0, S_IDLE, 0, 0, "after_load");

    foreach (tbl[i]) begin
      if (tbl[i].act == A_START) begin
        align();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else if (tbl[i].act == A_KEY) begin
        press(tbl[i].key);
      end
      seg(tbl[i].tone, tbl[i].n, tbl[i].lvl, tbl[i].st, tbl[i].m, tbl[i].gw,
          $sformatf("vec%0d", i));
    end

    // seq_we in WAIT_KEY must not replace the melody; key_valid in PLAY_ON is ignored.
    seq_in = '1; seq_we = 1'b1;
    @(posedge clk); #1;
    seq_we = 1'b0;
    seg(0, 4, 1, S_WAIT, 0, 0, "seqwe_in_wait");
    press(3);
    seg(3, 8, 1, S_ECHO, 0, 0, "echo_after_seqwe");
    seg(3, 2, 2, S_ON, 0, 0, "lvl2_replay_start");
    key_valid = 1'b1; key_code = 4'd5;
    @(posedge clk); #1;
    key_valid = 1'b0;
    seg(3, 6, 2, S_ON, 0, 0, "key_in_play_ignored");
    seg(0, 4, 2, S_OFF, 0, 0, "lvl2_off0");
    seg(6, 8, 2, S_ON, 0, 0, "old_melody_kept");
    seg(0, 4, 2, S_OFF, 0, 0, "lvl2_off1");
    seg(0, 1, 2, S_WAIT, 0, 0, "lvl2_wait");

    // Reset in the middle of an echo.
    press(3);
    seg(3, 3, 2, S_ECHO, 0, 0, "echo_before_reset");
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tone_out !== '0 || playing !== 1'b0 || miss !== 1'b0 || game_win !== 1'b0 ||
        level !== 5'd0 || state_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_echo: tone=%0d play=%0b miss=%0b win=%0b lvl=%0d st=%0d, required all 0",
               tone_out, playing, miss, game_win, level, state_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    seg(0, 12, 0, S_IDLE, 0, 0, "post_reset_quiet");

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seg(0, 6, 0, S_IDLE, 0, 0, "start_without_load");

    // WAIT_KEY with no key pressed.
    seq_in = SEQ; seq_we = 1'b1;
    @(posedge clk); #1;
    seq_we = 1'b0;
    align();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seg(3, 8, 1, S_ON, 0, 0, "to_play_on");
    seg(0, 4, 1, S_OFF, 0, 0, "to_play_off");
`ifdef MELODY_GAME_TIMEOUT_EN
    seg(0, 12, 1, S_WAIT, 0, 0, "timeout_wait");
    seg(3, 8, 1, S_ON, 1, 0, "timeout_replay");
`else
    seg(0, 40, 1, S_WAIT, 0, 0, "no_timeout_wait");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
